// File: rtl/digits10_decoder_if.sv
// digits10_decoder_if: row-in and digit-out valid/ready channels
// for the 5x5 glyph-to-digit decoder.
interface digits10_decoder_if;
  logic       row_valid;
  logic       row_ready;
  logic [7:0] row_bits;
  logic       row_first;
  logic       dig_valid;
  logic       dig_ready;
  logic [3:0] digit;
  logic       dig_match;
  logic       dig_err;

  modport master (
    output row_valid, row_bits, row_first, dig_ready,
    input  row_ready, dig_valid, digit, dig_match, dig_err
  );

  modport slave (
    input  row_valid, row_bits, row_first, dig_ready,
    output row_ready, dig_valid, digit, dig_match, dig_err
  );
endinterface

// File: rtl/digits10_decoder.sv
// digits10_decoder: buffers a 5-row glyph, scans the ten font
// patterns one per cycle and returns the matching digit code.
module digits10_decoder #(
  parameter logic [3:0] NO_MATCH_CODE = 4'hF
) (
  input logic          clk,
  input logic          reset,
  digits10_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    COLLECT,
    COMPARE,
    OUTPUT
  } state_t;

  // Glyph rows concatenated with row 0 in the MSBs.
  function automatic logic [24:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 25'b11111_10001_10001_10001_11111;
      4'd1:    font = 25'b01100_00100_00100_00100_11111;
      4'd2:    font = 25'b11111_00001_11111_10000_11111;
      4'd3:    font = 25'b11111_00001_11111_00001_11111;
      4'd4:    font = 25'b10001_10001_11111_00001_00001;
      4'd5:    font = 25'b11111_10000_11111_00001_11111;
      4'd6:    font = 25'b11111_10000_11111_10001_11111;
      4'd7:    font = 25'b11111_00001_00001_00001_00001;
      4'd8:    font = 25'b11111_10001_11111_10001_11111;
      4'd9:    font = 25'b11111_10001_11111_00001_11111;
      default: font = '0;
    endcase
  endfunction

  state_t     state_q;
  logic [4:0] rows_q [5];
  logic [2:0] cnt_q;
  logic [3:0] k_q;
  logic       err_q;
  logic       row_ready_q;
  logic       dig_valid_q;
  logic [3:0] digit_q;
  logic       match_q;
  logic       derr_q;

  logic        accept;
  logic        bad;
  logic [2:0]  idx;
  logic [24:0] glyph;

  assign accept = bus.row_valid && row_ready_q;
  assign bad    = |bus.row_bits[2:0];
  assign idx    = bus.row_first ? 3'd0 : cnt_q;
  assign glyph  = {rows_q[0], rows_q[1], rows_q[2],
                   rows_q[3], rows_q[4]};

  assign bus.row_ready = row_ready_q;
  assign bus.dig_valid = dig_valid_q;
  assign bus.digit     = digit_q;
  assign bus.dig_match = match_q;
  assign bus.dig_err   = derr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      k_q         <= '0;
      err_q       <= 1'b0;
      row_ready_q <= 1'b1;
      dig_valid_q <= 1'b0;
      digit_q     <= '0;
      match_q     <= 1'b0;
      derr_q      <= 1'b0;
      for (int i = 0; i < 5; i++) rows_q[i] <= '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            rows_q[idx] <= bus.row_bits[7:3];
            err_q <= bus.row_first ? bad : (err_q | bad);
            if (idx == 3'd4) begin
              state_q     <= COMPARE;
              cnt_q       <= '0;
              k_q         <= '0;
              row_ready_q <= 1'b0;
            end else begin
              cnt_q <= idx + 3'd1;
            end
          end
        end
        COMPARE: begin
          if (err_q) begin
            state_q     <= OUTPUT;
            dig_valid_q <= 1'b1;
            digit_q     <= NO_MATCH_CODE;
            match_q     <= 1'b0;
            derr_q      <= 1'b1;
          end else if (glyph == font(k_q)) begin
            state_q     <= OUTPUT;
            dig_valid_q <= 1'b1;
            digit_q     <= k_q;
            match_q     <= 1'b1;
            derr_q      <= 1'b0;
          end else if (k_q == 4'd9) begin
            state_q     <= OUTPUT;
            dig_valid_q <= 1'b1;
            digit_q     <= NO_MATCH_CODE;
            match_q     <= 1'b0;
            derr_q      <= 1'b0;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        OUTPUT: begin
          if (bus.dig_ready) begin
            state_q     <= COLLECT;
            dig_valid_q <= 1'b0;
            row_ready_q <= 1'b1;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/digits10_decoder.md
# digits10_decoder

Glyph-to-digit decoder for the team's 5x5 digit font; it is the inverse of the digit glyph ROM. It accepts a glyph one row at a time over a valid/ready handshake and buffers the five rows. It then scans the ten font patterns, one per cycle, and returns the matching digit code over a second valid/ready handshake. It sits downstream of any pixel/row source (frame capture, test stimulus) and gives the VGA test path a self-check loop: ROM row -> decoder -> digit.

## Interface
- NO_MATCH_CODE, default 4'hF: value driven on `digit` when no pattern matches or the glyph is malformed.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- row_valid  in  1  upstream has a row on `row_bits`.
- row_ready  out  1  decoder accepts a row this cycle; high only in COLLECT.
- row_bits  in  8  glyph row in ROM output format {pixels[4:0], 3'b000}; bit 7 is the leftmost pixel.
- row_first  in  1  qualifies `row_bits` as row 0 of a new glyph (resync).
- dig_valid  out  1  result available.
- dig_ready  in  1  downstream accepts the result.
- digit  out  4  decoded digit 0-9, or NO_MATCH_CODE.
- dig_match  out  1  1 = `digit` is a valid match.
- dig_err  out  1  1 = a row had nonzero bits[2:0] (malformed glyph).

## Operation
- Font, rows 0..4 as 5-bit values:
  - 0: 11111 10001 10001 10001 11111
  - 1: 01100 00100 00100 00100 11111
  - 2: 11111 00001 11111 10000 11111
  - 3: 11111 00001 11111 00001 11111
  - 4: 10001 10001 11111 00001 00001
  - 5: 11111 10000 11111 00001 11111
  - 6: 11111 10000 11111 10001 11111
  - 7: 11111 00001 00001 00001 00001
  - 8: 11111 10001 11111 10001 11111
  - 9: 11111 10001 11111 00001 11111
- All patterns are distinct, so a first match is the unique match.
- States: COLLECT, COMPARE, OUTPUT.
- COLLECT:
  - A beat is accepted when row_valid && row_ready. Rows are stored in a 5x5 buffer indexed by a 3-bit row counter (0..4).
  - A beat with row_first=1 discards any partial glyph: it is stored as row 0, the counter goes to 1, and the error flag is cleared to (bits[2:0]!=0).
  - Otherwise the row is stored at the counter index, the counter increments, and the error flag ORs in (bits[2:0]!=0).
  - When the accepted row is row 4, the next state is COMPARE, the counter returns to 0, and the pattern index k is set to 0.
- COMPARE:
  - Each cycle compares the buffer against pattern k.
  - On a match, or when the error flag is set (no scan is needed), the state goes to OUTPUT.
  - Otherwise k increments; after k=9 with no match, the state goes to OUTPUT with no match.
  - Result registers:
    - Match: digit=k, dig_match=1, dig_err=0.
    - No match: digit=NO_MATCH_CODE, dig_match=0, dig_err=0.
    - Error: digit=NO_MATCH_CODE, dig_match=0, dig_err=1.
- OUTPUT:
  - dig_valid=1. digit, dig_match and dig_err hold stable until dig_valid && dig_ready.
  - After the handshake, the state returns to COLLECT.
  - row_ready is 0 in both COMPARE and OUTPUT; row_valid is ignored there, including row_first.

## Timing
- Reset values: state=COLLECT, row_ready=1, dig_valid=0, digit=0, dig_match=0, dig_err=0, row counter=0, k=0, buffer=0, error flag=0.
- Asserting reset mid-glyph or mid-scan aborts the operation; no result is produced.
- Latency: the row 4 handshake registers at edge E.
  - Match at index k: dig_valid rises at edge E+1+k (digit 0 → E+1, digit 9 → E+10).
  - No match: dig_valid rises at edge E+10.
  - Error: dig_valid rises at edge E+1.
- The result handshake at edge F puts row_ready high in the cycle after F; results and rows never overlap.
- Minimum glyph period: 5 + (k+1) + 1 cycles with dig_ready tied high.
- row_valid may stay high across COMPARE/OUTPUT; those rows are not consumed until row_ready returns.

## Test plan
- Stream ROM rows of digits 0..9 back-to-back with dig_ready=1 → digits 0..9 out in order; each dig_match=1, dig_err=0; digit 7's dig_valid arrives 8 edges after its row 4.
- Glyph 11111 11111 11111 11111 11111 → digit=4'hF, dig_match=0, dig_err=0, dig_valid at E+10.
- Row 2 = 8'hF9 (low bits set) → dig_err=1, digit=4'hF, dig_valid at E+1.
- Send two rows of "8", then a row_first beat, then all five rows of "3" → the single result is digit=3; the partial glyph is dropped.
- Hold dig_ready=0 for 20 cycles → digit, dig_match and dig_err stable; row_ready=0 throughout; the result is released on the first dig_ready=1.
- Assert reset low during COMPARE of digit 9 → all outputs return to reset values immediately; no dig_valid pulse; the next glyph decodes correctly.
